sevenseg_scan_reader: RTL and testbench

//  Receive-side counterpart of the BCD-to-7-segment encoder: it snoops a time-multiplexed
//  7-segment display bus (shared segment lines plus one-hot digit select).
//  Per digit: waits for the bus to be stable, decodes abcdefg back to BCD, flags illegal patterns.

---
 rtl/sevenseg_scan_reader.sv | 183 ++++++++++++++++++
 tb/tb_sevenseg_scan_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_reader.sv
// sevenseg_scan_reader
//   Snoops a time-multiplexed 7-segment display bus and rebuilds the BCD digits.
//   Each digit is captured once after the bus has been stable for STABLE_CYC edges.
//   Its segments are decoded back to BCD, and illegal patterns are flagged.
//   A complete frame (all NDIG digits seen) is presented on a valid/ready interface.
//
// Parameters
//   NDIG        number of multiplexed digits (1..8)
//   STABLE_CYC  consecutive identical samples needed before capture (>=2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   seg        in   [6:0] segment lines abcdefg (bit6=a .. bit0=g)
//   dig_sel    in   [NDIG-1:0] one-hot digit enable, bit0 = rightmost digit
//   out_bcd    out  [4*NDIG-1:0] frame, digit i in [4i+3:4i], illegal -> 4'hF
//   out_err    out  [NDIG-1:0] per-digit illegal-pattern flag
//   out_valid  out  frame available
//   out_ready  in   consumer accepts frame when out_valid && out_ready
//   overrun    out  1-cycle pulse when a completed frame is dropped
//
// Build option
//   SEG_ACTIVE_LOW_EN : invert seg and dig_sel at the input (common-anode bus).

module sevenseg_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic [NDIG-1:0]     out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYC - 2);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state, state_nxt;

    logic [6:0]        seg_in;
    logic [NDIG-1:0]   sel_in;

    logic [6:0]        prev_seg;
    logic [NDIG-1:0]   prev_sel;
    logic [CW-1:0]     cnt;
    logic [NDIG-1:0]   seen;
    logic [4*NDIG-1:0] work_bcd;
    logic [NDIG-1:0]   work_err;

    logic              match;
    logic              one_hot;
    logic              capture;
    logic [3:0]        dec_bcd;
    logic              dec_err;
    logic [4*NDIG-1:0] work_bcd_nxt;
    logic [NDIG-1:0]   work_err_nxt;
    logic [NDIG-1:0]   seen_nxt;
    logic              frame_done;
    logic              load_out;
    logic              drop;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg;
    assign sel_in = ~dig_sel;
`else
    assign seg_in = seg;
    assign sel_in = dig_sel;
`endif

    // The current sample plus STABLE_CYC-1 earlier identical samples form the
    // window; cnt saturates so a held bus never reaches CNT_CAP again.
    always_comb begin
        match   = (seg_in == prev_seg) && (sel_in == prev_sel);
        one_hot = (sel_in != '0) && ((sel_in & (sel_in - NDIG'(1))) == '0);
        capture = match && (cnt == CNT_CAP) && one_hot;
    end

    always_comb begin
        dec_bcd = 4'hF;
        dec_err = 1'b0;
        case (seg_in)
            7'h7E:   dec_bcd = 4'd0;
            7'h30:   dec_bcd = 4'd1;
            7'h6D:   dec_bcd = 4'd2;
            7'h79:   dec_bcd = 4'd3;
            7'h33:   dec_bcd = 4'd4;
            7'h5B:   dec_bcd = 4'd5;
            7'h5F:   dec_bcd = 4'd6;
            7'h70:   dec_bcd = 4'd7;
            7'h7F:   dec_bcd = 4'd8;
            7'h73:   dec_bcd = 4'd9;
            default: dec_err = 1'b1;
        endcase
    end

    // Working registers including the digit captured this edge, so the frame
    // loaded on completion already contains the last digit.
    always_comb begin
        work_bcd_nxt = work_bcd;
        work_err_nxt = work_err;
        seen_nxt     = seen;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (capture && sel_in[i]) begin
                work_bcd_nxt[4*i +: 4] = dec_bcd;
                work_err_nxt[i]        = dec_err;
                seen_nxt[i]            = 1'b1;
            end
        end
        frame_done = capture && (seen_nxt == '1);
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (frame_done) begin
                    load_out  = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (frame_done) begin
                    if (out_ready) begin
                        load_out = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            prev_seg <= '0;
            prev_sel <= '0;
            cnt      <= '0;
            seen     <= '0;
            work_bcd <= '0;
            work_err <= '0;
            out_bcd  <= '0;
            out_err  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev_seg <= seg_in;
            prev_sel <= sel_in;
            if (!match) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            work_bcd <= work_bcd_nxt;
            work_err <= work_err_nxt;
            seen     <= frame_done ? '0 : seen_nxt;
            if (load_out) begin
                out_bcd <= work_bcd_nxt;
                out_err <= work_err_nxt;
            end
            overrun <= drop;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Testbench for sevenseg_scan_reader (NDIG=4, STABLE_CYC=4).
// Stimulus pushes expected frames into a queue; a monitor pops and compares
// whenever a frame is handed over (out_valid && out_ready).
// Define SEG_ACTIVE_LOW_EN for both files to exercise the inverted bus.

module tb_sevenseg_scan_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    always #5 clk = ~clk;

    sevenseg_scan_reader #(
        .NDIG       (NDIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned tests    = 0;
    int unsigned fails    = 0;
    int unsigned ovr_seen = 0;
    int unsigned ovr_exp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (overrun === 1'b1) ovr_seen++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got bcd %h err %b expected no frame", out_bcd, out_err);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    check("frame_bcd", 32'(out_bcd), 32'(f.bcd));
                    check("frame_err", 32'(out_err), 32'(f.err));
                end
            end else if (out_valid === 1'b1 && exp_q.size() != 0) begin
                check("hold_bcd", 32'(out_bcd), 32'(exp_q[0].bcd));
            end
        end
    end

    // Drive the bus (logical active-high values) and hold for n sampling edges.
    task automatic drive(input logic [3:0] sel, input logic [6:0] s, input int n);
`ifdef SEG_ACTIVE_LOW_EN
        dig_sel = ~sel;
        seg     = ~s;
`else
        dig_sel = sel;
        seg     = s;
`endif
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Last digit of a frame: out_valid must rise exactly at the STABLE_CYC-th edge.
    task automatic drive_last(input logic [3:0] sel, input logic [6:0] s, input int n);
`ifdef SEG_ACTIVE_LOW_EN
        dig_sel = ~sel;
        seg     = ~s;
`else
        dig_sel = sel;
        seg     = s;
`endif
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k == STABLE_CYC - 1) check("latency_early", 32'(out_valid), 32'd0);
            if (k == STABLE_CYC)     check("latency_rise", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 6);
        drive(4'b0010, s1, 6);
        drive(4'b0100, s2, 6);
        drive(4'b1000, s3, 6);
    endtask

    task automatic push(input logic [15:0] bcd, input logic [3:0] err);
        frame_t f;
        f.bcd = bcd;
        f.err = err;
        exp_q.push_back(f);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(4'b0000, 7'h00, 3);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_bcd", 32'(out_bcd), 32'd0);
        check("reset_err", 32'(out_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        drive(4'b0000, 7'h00, 2);

        // 1: basic in-order scan, latency on the last digit
        push(16'h3210, 4'b0000);
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0100, 7'h6D, 6);
        drive_last(4'b1000, 7'h79, 6);
        drive(4'b0000, 7'h00, 3);

        // 2: short (3-cycle) window on digit 2 must not capture
        push(16'h3210, 4'b0000);
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b1000, 7'h79, 6);
        drive(4'b0100, 7'h5B, 3);
        drive(4'b0000, 7'h00, 3);
        drive_last(4'b0100, 7'h6D, 6);
        drive(4'b0000, 7'h00, 3);

        // 3: illegal pattern on digit 1
        push(16'h32F0, 4'b0010);
        scan(7'h7E, 7'h01, 7'h6D, 7'h79);
        drive(4'b0000, 7'h00, 3);

        // 4: back-pressure, second frame dropped with one overrun pulse
        out_ready = 1'b0;
        push(16'h3210, 4'b0000);
        scan(7'h7E, 7'h30, 7'h6D, 7'h79);
        drive(4'b0000, 7'h00, 3);
        ovr_exp++;
        scan(7'h73, 7'h7F, 7'h70, 7'h5F);
        drive(4'b0000, 7'h00, 5);
        check("t4_held_valid", 32'(out_valid), 32'd1);
        check("t4_overrun_once", ovr_seen, ovr_exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_drop", 32'(out_valid), 32'd0);
        drive(4'b0000, 7'h00, 2);

        // 5: ghosted / blank selects ignored mid-frame
        push(16'h3210, 4'b0000);
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0110, 7'h7F, 10);
        drive(4'b0000, 7'h7F, 10);
        check("t5_no_frame", 32'(out_valid), 32'd0);
        drive(4'b0100, 7'h6D, 6);
        drive_last(4'b1000, 7'h79, 6);
        drive(4'b0000, 7'h00, 3);

        // 6: reset mid-frame discards digits 0-1; then out-of-order scan
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0000, 7'h00, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_reset_bcd", 32'(out_bcd), 32'd0);
        check("t6_reset_err", 32'(out_err), 32'd0);
        check("t6_reset_valid", 32'(out_valid), 32'd0);
        push(16'h6789, 4'b0000);
        drive(4'b0100, 7'h70, 6);
        drive(4'b1000, 7'h5F, 6);
        drive(4'b0000, 7'h00, 3);
        check("t6_no_partial", 32'(out_valid), 32'd0);
        drive(4'b0001, 7'h73, 6);
        drive_last(4'b0010, 7'h7F, 6);
        drive(4'b0000, 7'h00, 3);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("overrun_total", ovr_seen, ovr_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
